// File: rtl/mux_port_arbiter.sv
// Round-robin owner arbiter for the ALU's shared 4:1 operand/result mux, with a bounded hold time.
// Registered outputs: a request level seen at an edge drives gnt_o/sel_o/busy_o from that edge on.
module mux_port_arbiter #(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req_i,
  output logic [3:0] gnt_o,
  output logic [1:0] sel_o,
  output logic       busy_o
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = (HOLD_MAX == 0) ? '0 : CNT_W'(HOLD_MAX - 1);

  state_t           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             busy_q, busy_d;

  logic [3:0] others;
  logic       owner_req;
  logic [2:0] pick_idle, pick_next;
  logic       do_grant;
  logic [1:0] win;

  // Returns {found, index} of the first set bit of v searching upward from after+1, wrapping 3->0.
  function automatic logic [2:0] rr_pick(input logic [3:0] v, input logic [1:0] after);
    logic [1:0] idx;
    logic       found;
    rr_pick = '0;
    found   = 1'b0;
    idx     = '0;
    for (int i = 1; i < 5; i++) begin
      idx = after + 2'(i);
      if (!found && v[idx]) begin
        found   = 1'b1;
        rr_pick = {1'b1, idx};
      end
    end
  endfunction

  assign others    = req_i & ~gnt_q;
  assign owner_req = |(req_i & gnt_q);
  assign pick_idle = rr_pick(req_i, last_q);
  // In GRANT the owner is always last_q, so searching others after last_q is "next after owner".
  assign pick_next = rr_pick(others, last_q);

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    sel_d    = sel_q;
    last_d   = last_q;
    hold_d   = hold_q;
    do_grant = 1'b0;
    win      = '0;

    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (pick_idle[2]) begin
          do_grant = 1'b1;
          win      = pick_idle[1:0];
        end
      end
      GRANT: begin
        if (!owner_req) begin
          if (pick_next[2]) begin
            do_grant = 1'b1;
            win      = pick_next[1:0];
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            hold_d  = '0;
          end
        end else if ((HOLD_MAX != 0) && (hold_q == HOLD_LAST) && (others != 4'b0000)) begin
          do_grant = 1'b1;
          win      = pick_next[1:0];
        end else if (others != 4'b0000) begin
          if (hold_q != HOLD_LAST) begin
            hold_d = hold_q + 1'b1;
          end
        end else begin
          hold_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase

    if (do_grant) begin
      state_d = GRANT;
      gnt_d   = 4'b0001 << win;
      sel_d   = win;
      last_d  = win;
      hold_d  = '0;
    end

    busy_d = |gnt_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= 2'b00;
      last_q  <= 2'd3;
      hold_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt_o  = gnt_q;
  assign sel_o  = sel_q;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_mux_port_arbiter.sv
// Directed bench for mux_port_arbiter: one instance with unlimited hold, one with HOLD_MAX=8.
module tb_mux_port_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req0, req8;
  logic [3:0] gnt0, gnt8;
  logic [1:0] sel0, sel8;
  logic       busy0, busy8;

  int n_vec = 0;
  int n_err = 0;

  mux_port_arbiter #(.HOLD_MAX(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .req_i(req0), .gnt_o(gnt0), .sel_o(sel0), .busy_o(busy0)
  );

  mux_port_arbiter #(.HOLD_MAX(8), .CNT_W(4)) dut8 (
    .clk(clk), .rst(rst), .req_i(req8), .gnt_o(gnt8), .sel_o(sel8), .busy_o(busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs packed as {gnt, sel, busy}.
  function automatic logic [6:0] v(input logic [3:0] g, input logic [1:0] s, input logic b);
    return {g, s, b};
  endfunction

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got gnt/sel/busy=%b/%b/%b expected %b/%b/%b",
               tag, obs[6:3], obs[2:1], obs[0], exp[6:3], exp[2:1], exp[0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] order [5];
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst  = 1'b1;
    req0 = 4'b0000;
    req8 = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_dut0", v(gnt0, sel0, busy0), v(4'b0000, 2'd0, 1'b0));
    chk("reset_dut8", v(gnt8, sel8, busy8), v(4'b0000, 2'd0, 1'b0));

    // 1: release reset with no requests
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("idle_dut0_c%0d", i), v(gnt0, sel0, busy0), v(4'b0000, 2'd0, 1'b0));
      chk($sformatf("idle_dut8_c%0d", i), v(gnt8, sel8, busy8), v(4'b0000, 2'd0, 1'b0));
    end

    // 2: all requesting, owner drops for one cycle after each grant, unlimited hold
    req0 = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("rr_grant%0d", i), v(gnt0, sel0, busy0), v(order[i], 2'(i % 4), 1'b1));
      req0 = 4'b1111 & ~gnt0;
    end
    req0 = 4'b0000;

    // 3: requester 2 holds, requester 0 arrives two cycles later and preempts after 8 cycles
    req8 = 4'b0100;
    step();
    chk("hold_first_grant", v(gnt8, sel8, busy8), v(4'b0100, 2'd2, 1'b1));
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("hold_alone_c%0d", i), v(gnt8, sel8, busy8), v(4'b0100, 2'd2, 1'b1));
    end
    req8 = 4'b0101;
    for (int i = 1; i <= 7; i++) begin
      step();
      chk($sformatf("hold_contend_c%0d", i), v(gnt8, sel8, busy8), v(4'b0100, 2'd2, 1'b1));
    end
    step();
    chk("preempt_to_0", v(gnt8, sel8, busy8), v(4'b0001, 2'd0, 1'b1));

    // 4: single requester keeps the mux indefinitely
    req8 = 4'b0000;
    step();
    chk("drop_to_idle", v(gnt8, sel8, busy8), v(4'b0000, 2'd0, 1'b0));
    req8 = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("single_hold_c%0d", i), v(gnt8, sel8, busy8), v(4'b0010, 2'd1, 1'b1));
    end

    // 5: owner 1 drops while 3 and 0 rise together -> 3 first, then 0
    req8 = 4'b1001;
    step();
    chk("handoff_to_3", v(gnt8, sel8, busy8), v(4'b1000, 2'd3, 1'b1));
    req8 = 4'b0001;
    step();
    chk("handoff_to_0", v(gnt8, sel8, busy8), v(4'b0001, 2'd0, 1'b1));

    // Idle keeps the previous select value
    req8 = 4'b0100;
    step();
    chk("handoff_to_2", v(gnt8, sel8, busy8), v(4'b0100, 2'd2, 1'b1));
    req8 = 4'b0000;
    step();
    chk("idle_sel_held", v(gnt8, sel8, busy8), v(4'b0000, 2'd2, 1'b0));
    req8 = 4'b0100;
    step();
    chk("regrant_2", v(gnt8, sel8, busy8), v(4'b0100, 2'd2, 1'b1));

    // 6: asynchronous reset mid-cycle during a grant
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset", v(gnt8, sel8, busy8), v(4'b0000, 2'd0, 1'b0));
    req8 = 4'b1111;
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("post_reset_to_0", v(gnt8, sel8, busy8), v(4'b0001, 2'd0, 1'b1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
